// File: rtl/generic_bus_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ generic-bus masters onto one slave.
// Optional bus locking enabled by defining GENERIC_BUS_ARB_LOCK_EN.
module generic_bus_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    localparam int unsigned BE_W   = DATA_W / 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*BE_W-1:0]   req_byte_en,
    input  logic [NUM_REQ-1:0]        req_ren,
    input  logic [NUM_REQ-1:0]        req_wen,
    output logic [NUM_REQ*DATA_W-1:0] req_rdata,
    output logic [NUM_REQ-1:0]        req_busy,
`ifdef GENERIC_BUS_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [ADDR_W-1:0]         slv_addr,
    output logic [DATA_W-1:0]         slv_wdata,
    output logic [BE_W-1:0]           slv_byte_en,
    output logic                      slv_ren,
    output logic                      slv_wen,
    input  logic [DATA_W-1:0]         slv_rdata,
    input  logic                      slv_busy
);

    localparam int unsigned GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [GNT_W-1:0] gnt, gnt_nxt;
    logic [GNT_W-1:0] rr_ptr, rr_nxt;
    logic [GNT_W-1:0] gnt_inc;
    logic [GNT_W-1:0] pick;
    logic             found;

    logic [NUM_REQ-1:0] active;
    logic               gnt_ren, gnt_wen, gnt_lock;
    logic [ADDR_W-1:0]  gnt_addr;
    logic [DATA_W-1:0]  gnt_wdata;
    logic [BE_W-1:0]    gnt_be;

    assign active    = req_ren | req_wen;
    assign req_rdata = {NUM_REQ{slv_rdata}};
    assign gnt_inc   = (gnt == GNT_W'(NUM_REQ - 1)) ? '0 : gnt + GNT_W'(1);

    // Slices of the currently granted requestor.
    always_comb begin
        gnt_ren   = 1'b0;
        gnt_wen   = 1'b0;
        gnt_lock  = 1'b0;
        gnt_addr  = '0;
        gnt_wdata = '0;
        gnt_be    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt == GNT_W'(i)) begin
                gnt_ren   = req_ren[i];
                gnt_wen   = req_wen[i];
`ifdef GENERIC_BUS_ARB_LOCK_EN
                gnt_lock  = req_lock[i];
`endif
                gnt_addr  = req_addr[i*ADDR_W +: ADDR_W];
                gnt_wdata = req_wdata[i*DATA_W +: DATA_W];
                gnt_be    = req_byte_en[i*BE_W +: BE_W];
            end
        end
    end

    // First active requestor at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && (j == idx) && active[j]) begin
                    found = 1'b1;
                    pick  = GNT_W'(j);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            gnt    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    // Next state plus slave-side and busy outputs; strobes follow the granted
    // requestor combinationally so an abort withdraws them in the same cycle.
    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        rr_nxt      = rr_ptr;
        slv_addr    = '0;
        slv_wdata   = '0;
        slv_byte_en = '0;
        slv_ren     = 1'b0;
        slv_wen     = 1'b0;
        req_busy    = '1;

        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = pick;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                slv_addr    = gnt_addr;
                slv_wdata   = gnt_wdata;
                slv_byte_en = gnt_be;
                slv_wen     = gnt_wen;
                slv_ren     = gnt_ren & ~gnt_wen;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (gnt == GNT_W'(i)) req_busy[i] = slv_busy;
                end
                if (!(gnt_ren | gnt_wen)) begin
                    state_nxt = IDLE;
                end else if (!slv_busy && !gnt_lock) begin
                    state_nxt = IDLE;
                    rr_nxt    = gnt_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// Scoreboard bench for generic_bus_arbiter with four requestors and a wait-state slave.
`timescale 1ns/1ps
module tb_generic_bus_arbiter;

    localparam int NR = 4;

    logic           CLK = 1'b0;
    logic           RST;
    logic [NR*32-1:0] req_addr;
    logic [NR*32-1:0] req_wdata;
    logic [NR*4-1:0]  req_byte_en;
    logic [NR-1:0]    req_ren, req_wen, req_lock;
    logic [NR*32-1:0] req_rdata;
    logic [NR-1:0]    req_busy;
    logic [31:0]      slv_addr, slv_wdata, slv_rdata;
    logic [3:0]       slv_byte_en;
    logic             slv_ren, slv_wen, slv_busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] data;
    } xfer_t;
    xfer_t sb[$];

    generic_bus_arbiter #(.NUM_REQ(NR), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_en(req_byte_en),
        .req_ren(req_ren), .req_wen(req_wen),
        .req_rdata(req_rdata), .req_busy(req_busy),
`ifdef GENERIC_BUS_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_byte_en(slv_byte_en),
        .slv_ren(slv_ren), .slv_wen(slv_wen),
        .slv_rdata(slv_rdata), .slv_busy(slv_busy)
    );

    always #5 CLK = ~CLK;

    // Slave model: holds busy for 'waits' cycles of an asserted strobe.
    int         waits = 0;
    logic [7:0] wcnt;
    always_comb slv_busy = (slv_ren | slv_wen) && (int'(wcnt) < waits);
    always @(posedge CLK) begin
        if (RST || !(slv_ren | slv_wen) || !slv_busy) wcnt <= 8'd0;
        else wcnt <= wcnt + 8'd1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] busy_low(input int i);
        return ~(4'b0001 << i);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic ren, input logic wen,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_ren[i] = ren;
        req_wen[i] = wen;
        req_addr[i*32 +: 32]   = a;
        req_wdata[i*32 +: 32]  = d;
        req_byte_en[i*4 +: 4]  = be;
    endtask

    task automatic clr_all();
        req_ren  = '0;
        req_wen  = '0;
        req_lock = '0;
    endtask

    task automatic push(input int idx, input logic [31:0] a, input logic w, input logic [31:0] d);
        xfer_t e;
        e.idx = idx; e.addr = a; e.wen = w; e.data = d;
        sb.push_back(e);
    endtask

    // Completion monitor: pops the scoreboard on every finished slave access.
    always @(negedge CLK) begin
        if (!RST && (slv_ren || slv_wen) && !slv_busy) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(1), 64'(0));
            end else begin
                xfer_t e;
                e = sb.pop_front();
                chk("sb_addr", 64'(slv_addr), 64'(e.addr));
                chk("sb_wen",  64'(slv_wen),  64'(e.wen));
                chk("sb_busy", 64'(req_busy), 64'(busy_low(e.idx)));
                if (e.wen) chk("sb_wdata", 64'(slv_wdata), 64'(e.data));
                else       chk("sb_rdata", 64'(req_rdata[e.idx*32 +: 32]), 64'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, hi;
        logic done;
        RST = 1'b1;
        req_addr = '0; req_wdata = '0; req_byte_en = '0;
        clr_all();
        slv_rdata = 32'h0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 32'h10 * i, 32'h0, 4'hF);

        // Reset with all requestors active
        step(); step();
        @(negedge CLK);
        chk("rst_ren",   64'(slv_ren), 64'(0));
        chk("rst_wen",   64'(slv_wen), 64'(0));
        chk("rst_busy",  64'(req_busy), 64'(4'hF));
        chk("rst_addr",  64'(slv_addr), 64'(0));
        chk("rst_wdata", 64'(slv_wdata), 64'(0));
        chk("rst_be",    64'(slv_byte_en), 64'(0));
        chk("rst_rdata", 64'(req_rdata[63:0]), 64'(0));
        step();
        RST = 1'b0;
        push(0, 32'h0, 1'b0, 32'h0);
        @(negedge CLK);
        chk("post_rst_idle", 64'(slv_ren), 64'(0));
        step();
        @(negedge CLK);
        chk("first_gnt_ren",  64'(slv_ren), 64'(1));
        chk("first_gnt_busy", 64'(req_busy), 64'(4'hE));
        step();
        clr_all();

        // Single read, zero-wait slave
        set_req(1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        slv_rdata = 32'hDEADBEEF;
        push(1, 32'h100, 1'b0, 32'hDEADBEEF);
        @(negedge CLK);
        chk("rd_t_idle", 64'(slv_ren), 64'(0));
        step();
        @(negedge CLK);
        chk("rd_ren",   64'(slv_ren), 64'(1));
        chk("rd_addr",  64'(slv_addr), 64'(32'h100));
        chk("rd_busy",  64'(req_busy), 64'(4'hD));
        chk("rd_rdata", 64'(req_rdata[63:32]), 64'(32'hDEADBEEF));
        step();
        clr_all();
        @(negedge CLK);
        chk("rd_t2_ren",  64'(slv_ren), 64'(0));
        chk("rd_t2_busy", 64'(req_busy), 64'(4'hF));

        // Round robin: four continuous writers, two wait states
        step();
        RST = 1'b1;
        waits = 2;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b1, 32'h2000 + 32'(i*4), 32'hA0 + 32'(i), 4'hF);
        for (int k = 0; k < 5; k++) push(k % NR, 32'h2000 + 32'((k % NR) * 4), 1'b1, 32'hA0 + 32'(k % NR));
        step();
        RST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc = 0;
            @(negedge CLK);
            while (!slv_wen && cyc < 10) begin
                @(negedge CLK);
                cyc++;
            end
            chk("rr_grant_seen", 64'(slv_wen), 64'(1));
            hi = 0;
            done = 1'b0;
            while (!done && hi < 10) begin
                hi++;
                chk("rr_busy", 64'(req_busy), 64'(slv_busy ? 4'hF : busy_low(k % NR)));
                if (!slv_busy) done = 1'b1;
                else @(negedge CLK);
            end
            chk("rr_hold", 64'(hi), 64'(3));
        end
        step();
        clr_all();
        waits = 0;

        // Simultaneous ren and wen: write wins
        step();
        set_req(0, 1'b1, 1'b1, 32'h3000, 32'h55AA, 4'b0011);
        push(0, 32'h3000, 1'b1, 32'h55AA);
        @(negedge CLK);
        step();
        @(negedge CLK);
        chk("both_wen", 64'(slv_wen), 64'(1));
        chk("both_ren", 64'(slv_ren), 64'(0));
        chk("both_be",  64'(slv_byte_en), 64'(4'b0011));
        step();
        clr_all();

        // Abort while busy; rr_ptr must not advance
        waits = 100;
        set_req(3, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
        @(negedge CLK);
        step();
        @(negedge CLK);
        chk("abort_pre_ren",  64'(slv_ren), 64'(1));
        chk("abort_pre_busy", 64'(req_busy), 64'(4'hF));
        step();
        clr_all();
        @(negedge CLK);
        chk("abort_same_cycle", 64'(slv_ren), 64'(0));
        step();
        @(negedge CLK);
        chk("abort_idle_ren",  64'(slv_ren), 64'(0));
        chk("abort_idle_busy", 64'(req_busy), 64'(4'hF));
        step();
        waits = 0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 32'h500 + 32'(i*4), 32'h0, 4'hF);
        push(1, 32'h504, 1'b0, 32'hDEADBEEF);
        @(negedge CLK);
        step();
        @(negedge CLK);
        chk("abort_rr_kept", 64'(slv_addr), 64'(32'h504));
        step();
        clr_all();

        // Reset during a busy write
        waits = 100;
        set_req(2, 1'b0, 1'b1, 32'h600, 32'h66, 4'hF);
        @(negedge CLK);
        step();
        @(negedge CLK);
        chk("rstw_wen_pre", 64'(slv_wen), 64'(1));
        step();
        RST = 1'b1;
        step();
        @(negedge CLK);
        chk("rstw_wen",   64'(slv_wen), 64'(0));
        chk("rstw_addr",  64'(slv_addr), 64'(0));
        chk("rstw_wdata", 64'(slv_wdata), 64'(0));
        chk("rstw_be",    64'(slv_byte_en), 64'(0));
        chk("rstw_busy",  64'(req_busy), 64'(4'hF));
        step();
        RST = 1'b0;
        clr_all();
        waits = 0;

`ifdef GENERIC_BUS_ARB_LOCK_EN
        // Locked back-to-back writes by requestor 2
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        step();
        set_req(2, 1'b0, 1'b1, 32'h700, 32'h77, 4'hF);
        req_lock[2] = 1'b1;
        for (int k = 0; k < 3; k++) push(2, 32'h700, 1'b1, 32'h77);
        push(0, 32'h800, 1'b1, 32'h88);
        @(negedge CLK);
        step();
        set_req(0, 1'b0, 1'b1, 32'h800, 32'h88, 4'hF);
        @(negedge CLK);
        chk("lock_1", 64'(req_busy), 64'(4'hB));
        step();
        @(negedge CLK);
        chk("lock_2", 64'(req_busy), 64'(4'hB));
        step();
        req_lock[2] = 1'b0;
        @(negedge CLK);
        chk("lock_3", 64'(req_busy), 64'(4'hB));
        step();
        req_wen[2] = 1'b0;
        @(negedge CLK);
        chk("lock_idle", 64'(slv_wen), 64'(0));
        step();
        @(negedge CLK);
        chk("lock_then_0",  64'(req_busy), 64'(4'hE));
        chk("lock_0_addr",  64'(slv_addr), 64'(32'h800));
        step();
        clr_all();
`endif

        step();
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
